sevenseg_scan_ctrl: RTL
=======================

Name: sevenseg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode/cathode multi-digit 7-segment display. Holds a NUM_DIGITS-nibble hex value, shares one nibble-to-segment decoder across all digits, and sequences anode enables with an anti-ghosting blank gap. Sits between the hex-value producers and the board display pins; display content changes only at frame boundaries.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
CLK_DIV, 50000, clocks each digit is driven per visit (>=1)
BLANK_CYCLES, 16, clocks with all anodes off before each digit (>=1)
AN_ACTIVE_LOW, 1, 1 = anode outputs active-low; 0 = active-high

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  1 = scan; 0 = display dark
load  in  1  one-cycle strobe capturing value/dp_in
value  in  4*NUM_DIGITS  hex nibbles; value[3:0] = digit 0 (rightmost)
dp_in  in  NUM_DIGITS  decimal point per digit
seg  out  [0:7]  segments a,b,c,d,e,f,g,dp; 1 = lit
an  out  NUM_DIGITS  digit enables, polarity per AN_ACTIVE_LOW
digit_idx  out  clog2(NUM_DIGITS)  digit currently selected
frame_done  out  1  one-cycle pulse at end of last digit's DRIVE

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high (rst).
- Reset (immediate, no clock needed): state IDLE, seg=8'b0, an=all inactive, digit_idx=0, frame_done=0, display reg=0, pending reg=0, pending_valid=0, counter=0.
- load: pending <= {dp_in,value}, pending_valid <= 1. Repeated loads before transfer: latest wins.
- Frame boundary = IDLE->BLANK or DRIVE(last digit)->BLANK(digit 0). At boundary: if load same cycle, display <= inputs directly and pending_valid <= 0; else if pending_valid, display <= pending, pending_valid <= 0.
- FSM: IDLE --enable--> BLANK. BLANK: all anodes inactive, counter runs BLANK_CYCLES clocks, then DRIVE. DRIVE: an[digit_idx] active, seg = decode(display nibble digit_idx) with dp, for CLK_DIV clocks; then digit_idx+1 (wrap NUM_DIGITS-1 -> 0) and BLANK. frame_done pulses on the DRIVE->BLANK edge leaving the last digit.
- seg/an registered; they take the new state's values on the same edge that enters the state. During BLANK, seg=0.
- enable=0 in any state: next edge -> IDLE, an inactive, seg=0, digit_idx=0, counter=0; pending retained. Re-enable restarts at digit 0 (boundary rules apply).
- Frame period = NUM_DIGITS*(BLANK_CYCLES+CLK_DIV) clocks.
- Decoder: 0-F standard hex glyphs (b, d lowercase).

Optional Feature:
LEADING_ZERO_BLANK_EN: when defined, digits above the most significant nonzero nibble of display show seg[0:6]=0 (dp still honoured); digit 0 always shown; anode timing unchanged. When undefined, every digit shows its glyph, including leading zeros.

Decomposition:
- Shared include sevenseg_defs.vh: 16 segment glyph constants ([0:6], a..g order), SEG_OFF, FSM state encodings (IDLE, BLANK, DRIVE).
- One sub-module: hex_nibble_to_7seg (combinational 4-bit -> [0:6] decoder), instantiated once, fed by the digit mux.

Test Plan (NUM_DIGITS=4, CLK_DIV=4, BLANK_CYCLES=1, AN_ACTIVE_LOW=1):
1. Reset, load value=16'h1234 dp_in=0, enable=1 -> first DRIVE: an=4'b1110, seg=8'b01100110 ("4"); then digits show 3,2,1 with an 1101,1011,0111.
2. Steady scan -> each an low exactly 4 clocks, 1-clock all-ones gap, frame_done one pulse every 20 clocks, digit_idx 0..3 wrapping.
3. Load 16'hABCD during digit 1 DRIVE -> digits 2,3 still show 2,1; next frame shows D,C,b,A.
4. enable=0 mid-DRIVE -> next edge an=4'b1111, seg=0, digit_idx=0; enable=1 -> restarts at digit 0 after 1 blank clock.
5. rst pulsed mid-frame between edges -> an=4'b1111, seg=0, frame_done=0 immediately; display reg cleared, shows 0000 after re-enable.
6. value=16'h0050 -> macro defined: digits 3,2 seg=0, digit 1 "5", digit 0 "0"; macro undefined: digits show 0,0,5,0.

Source files
------------

// File: rtl/sevenseg_scan_ctrl_pkg.sv
// Shared glyphs, FSM encodings and sizing helper for the 7-segment scan controller.
// The optional LEADING_ZERO_BLANK_EN macro is consumed by sevenseg_scan_ctrl.
package sevenseg_scan_ctrl_pkg;

  // Segment order a..g, index 0 = segment a; 1 = lit.
  typedef logic [0:6] glyph_t;

  localparam glyph_t GLYPH_0 = 7'b1111110;
  localparam glyph_t GLYPH_1 = 7'b0110000;
  localparam glyph_t GLYPH_2 = 7'b1101101;
  localparam glyph_t GLYPH_3 = 7'b1111001;
  localparam glyph_t GLYPH_4 = 7'b0110011;
  localparam glyph_t GLYPH_5 = 7'b1011011;
  localparam glyph_t GLYPH_6 = 7'b1011111;
  localparam glyph_t GLYPH_7 = 7'b1110000;
  localparam glyph_t GLYPH_8 = 7'b1111111;
  localparam glyph_t GLYPH_9 = 7'b1111011;
  localparam glyph_t GLYPH_A = 7'b1110111;
  localparam glyph_t GLYPH_B = 7'b0011111;
  localparam glyph_t GLYPH_C = 7'b1001110;
  localparam glyph_t GLYPH_D = 7'b0111101;
  localparam glyph_t GLYPH_E = 7'b1001111;
  localparam glyph_t GLYPH_F = 7'b1000111;
  localparam glyph_t SEG_OFF = 7'b0000000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// Producer/display-side bundle of the scan controller: load/enable inputs and registered pin outputs.
interface sevenseg_scan_ctrl_if
  import sevenseg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) ();

  localparam int IDX_W = bits_for(NUM_DIGITS);

  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [0:7]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_done;

  modport master (
    output enable, load, value, dp_in,
    input  seg, an, digit_idx, frame_done
  );

  modport slave (
    input  enable, load, value, dp_in,
    output seg, an, digit_idx, frame_done
  );

endinterface

// File: rtl/hex_nibble_to_7seg.sv
// Combinational hex nibble to a..g segment decoder; b and d use lowercase glyphs.
module hex_nibble_to_7seg
  import sevenseg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output glyph_t     glyph
);

  always_comb begin
    glyph = SEG_OFF;
    case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed 7-segment scanner: BLANK gap then DRIVE per digit, registered seg/an, content swaps only at frame start.
// Optional LEADING_ZERO_BLANK_EN macro dims digits above the most significant nonzero nibble.
module sevenseg_scan_ctrl
  import sevenseg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int CLK_DIV       = 50000,
  parameter int BLANK_CYCLES  = 16,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst,
  sevenseg_scan_ctrl_if.slave bus
);

  localparam int IDX_W   = bits_for(NUM_DIGITS);
  localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_W   = bits_for(CNT_MAX);
  localparam int VAL_W   = 4 * NUM_DIGITS;

  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [VAL_W-1:0]      disp_val;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [VAL_W-1:0]      pend_val;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pending_valid;
  logic [0:7]            seg_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic                  frame_done_r;

  logic                  blank_done;
  logic                  drive_done;
  logic                  last_digit;
  logic                  boundary;
  logic [3:0]            nibble;
  logic                  cur_dp;
  logic [NUM_DIGITS-1:0] onehot;
  logic                  digit_lit;
  glyph_t                glyph;
  glyph_t                shown_glyph;

  assign blank_done = (cnt == CNT_W'(BLANK_CYCLES - 1));
  assign drive_done = (cnt == CNT_W'(CLK_DIV - 1));
  assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));

  // Frame start: leaving IDLE, or wrapping from the last digit's DRIVE back to digit 0.
  assign boundary = bus.enable &&
                    ((state == ST_IDLE) ||
                     (state == ST_DRIVE && drive_done && last_digit));

  // Single shared decoder; the digit mux selects which nibble it sees.
  always_comb begin
    nibble = 4'h0;
    cur_dp = 1'b0;
    onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nibble    = disp_val[4*i +: 4];
        cur_dp    = disp_dp[i];
        onehot[i] = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msd;

  always_comb begin
    msd = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (disp_val[4*i +: 4] != 4'h0) msd = IDX_W'(i);
    end
  end

  // msd floors at 0, so digit 0 is always lit.
  assign digit_lit = (idx <= msd);
`else
  assign digit_lit = 1'b1;
`endif

  hex_nibble_to_7seg u_dec (
    .nibble (nibble),
    .glyph  (glyph)
  );

  assign shown_glyph = digit_lit ? glyph : SEG_OFF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      idx           <= '0;
      disp_val      <= '0;
      disp_dp       <= '0;
      pend_val      <= '0;
      pend_dp       <= '0;
      pending_valid <= 1'b0;
      seg_r         <= '0;
      an_r          <= AN_OFF;
      frame_done_r  <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;

      if (bus.load) begin
        pend_val      <= bus.value;
        pend_dp       <= bus.dp_in;
        pending_valid <= 1'b1;
      end

      // A load coinciding with the boundary bypasses the pending register.
      if (boundary) begin
        if (bus.load) begin
          disp_val      <= bus.value;
          disp_dp       <= bus.dp_in;
          pending_valid <= 1'b0;
        end else if (pending_valid) begin
          disp_val      <= pend_val;
          disp_dp       <= pend_dp;
          pending_valid <= 1'b0;
        end
      end

      if (!bus.enable) begin
        state <= ST_IDLE;
        cnt   <= '0;
        idx   <= '0;
        seg_r <= '0;
        an_r  <= AN_OFF;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_BLANK;
            cnt   <= '0;
            idx   <= '0;
            seg_r <= '0;
            an_r  <= AN_OFF;
          end
          ST_BLANK: begin
            if (blank_done) begin
              state <= ST_DRIVE;
              cnt   <= '0;
              seg_r <= {shown_glyph, cur_dp};
              an_r  <= AN_OFF ^ onehot;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_DRIVE: begin
            if (drive_done) begin
              state        <= ST_BLANK;
              cnt          <= '0;
              idx          <= last_digit ? '0 : idx + IDX_W'(1);
              seg_r        <= '0;
              an_r         <= AN_OFF;
              frame_done_r <= last_digit;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            seg_r <= '0;
            an_r  <= AN_OFF;
          end
        endcase
      end
    end
  end

  assign bus.seg        = seg_r;
  assign bus.an         = an_r;
  assign bus.digit_idx  = idx;
  assign bus.frame_done = frame_done_r;

endmodule
